bird_datapath: RTL
==================

// Module: bird_datapath
// PURPOSE
//  Datapath end of the bird control/datapath interface. Decodes the 4-bit bird state code, and owns the bird Y position and motion timing.
//  Returns the status inputs to the bird FSM: flag (too high) and touched (collision).
//  Streams erase/paint pixel writes for the bird sprite to the VGA adapter.
// PARAMETERS
//  FRAME_CYCLES  833333  clk cycles per motion frame (60 Hz at 50 MHz)
//  BIRD_X        8'd40   fixed sprite left column
//  BIRD_W/BIRD_H 4/4     sprite size in pixels (each 1..15)
//  START_Y       7'd56   Y loaded in START; TOP_Y 7'd4 flag threshold; GROUND_Y 7'd116 floor row
//  RISE_STEP     2       pixels up per frame in RAISING; FALL_STEP 1 pixels down per frame in FALLING
//  BIRD_COL/BG_COL 3'b110/3'b000  paint and erase colours
// PORTS
//  clk       in  1  system clock
//  reset     in  1  asynchronous, active-high reset
//  state     in  4  FSM code: 0 START,1 RAISING,2 FALLING,3 STOP,4 DRAW,E UPDATE,F DEL
//  pipe_hit  in  1  level from pipe logic: bird box overlaps a pipe
//  flag      out 1  registered; 1 when y <= TOP_Y
//  touched   out 1  registered; 1 when y >= GROUND_Y-BIRD_H or pipe_hit
//  x         out 8  pixel column; y_pix out 7 pixel row; colour out 3
//  plot      out 1  pixel write strobe, one pixel per cycle
//  busy      out 1  sprite sequencer not IDLE
// BEHAVIOUR
//  Reset: y=START_Y, old_y=START_Y, frame counter 0, flag=0, touched=0, plot=0, busy=0, x=0, y_pix=0, colour=0, pending=0, seq=IDLE.
//  Frame divider: counts 0..FRAME_CYCLES-1. tick is a 1-cycle pulse at wrap. The divider free-runs in all states.
//  Motion is applied on tick only, and only when seq==IDLE. A tick seen while busy sets pending; the move runs on the first IDLE cycle after that, and pending clears.
//  Only one move is pending at a time. Further ticks while pending is set are dropped.
//  Motion rules:
//   START: y<=START_Y immediately, no tick needed. The frame counter is not reset.
//   RAISING: y<=max(y-RISE_STEP,0).
//   FALLING: y<=min(y+FALL_STEP,GROUND_Y-BIRD_H).
//   STOP, DRAW, UPDATE, DEL and undefined codes: y holds.
//  Arithmetic: 8-bit signed intermediate before the clamp, so no wrap at row 0.
//  Status outputs: flag and touched update every cycle from the registered y and the current pipe_hit, with 1 cycle latency.
//   In STOP, y sits at the floor, so touched stays 1. The FSM then moves to START, y reloads, and touched drops 1 cycle later.
//  Sprite sequencer states:
//   IDLE: starts when y!=old_y, or on the first DRAW code after reset. Goes to ERASE.
//   ERASE: BIRD_W*BIRD_H pixels at (BIRD_X+i, old_y+j), colour BG_COL. Goes to PAINT.
//   PAINT: same scan at the new y, colour BIRD_COL. At the end old_y<=y and seq returns to IDLE.
//   Scan order: row-major, i fastest. plot=1 on every ERASE/PAINT cycle. busy=1 outside IDLE.
//   Latency: tick to first plot is 2 cycles. One redraw is 2*W*H cycles.
//  Simultaneous events:
//   A state change during ERASE/PAINT does not abort the scan.
//   START during a scan updates y, and the new value is used by PAINT if PAINT has not started yet.
//  Reset mid-scan: plot drops at once, with no partial-row completion.
// CONFIGURATION
//  BIRD_GRAVITY_EN defined: FALLING adds a 3-bit velocity v to y each tick, then v<=min(v+1,7).
//   v clears to 0 in START, RAISING and at reset. Clamping is unchanged.
//  Undefined: constant FALL_STEP. The v register is not built.
// STRUCTURE
//  Shared package bird_pkg: the state code localparams (shared with the bird FSM), the screen limits, and the colour constants.
//  One sub-module, sprite_scanner: i/j counters, ERASE/PAINT sequencing, and pixel outputs.
//  Motion, divider and status logic stay in the top module.
// TESTING
//  Run with FRAME_CYCLES=4.
//  Reset asserted mid-PAINT -> plot=0 and y=56 in the same cycle. After release busy=0 and touched=0.
//  state=1 for 3 ticks from y=56 -> y=50. Each move gives 16 ERASE then 16 PAINT plots, colours 000 then 110.
//  state=1 from y=5 -> y=3 after 1 tick, flag=1 next cycle. Further ticks give y=1, then y=0, with no wrap.
//  state=2 from y=110 -> y stops at 112, touched=1. state=3 then 0 -> y=56, touched=0 1 cycle later.
//  pipe_hit pulse 1 cycle while state=2 -> touched high exactly 1 cycle, delayed 1.
//  Tick arriving while busy -> move deferred until the IDLE cycle after the scan, and only one move occurs.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared bird definitions: FSM state codes (also used by the bird FSM),
// sprite sequencer states, screen limits and sprite colours.
package bird_pkg;

  // Bird FSM state codes driven onto the datapath's state input
  localparam logic [3:0] StStart   = 4'h0;
  localparam logic [3:0] StRaising = 4'h1;
  localparam logic [3:0] StFalling = 4'h2;
  localparam logic [3:0] StStop    = 4'h3;
  localparam logic [3:0] StDraw    = 4'h4;
  localparam logic [3:0] StUpdate  = 4'hE;
  localparam logic [3:0] StDel     = 4'hF;

  // Screen limits
  localparam logic [6:0] TopY    = 7'd4;
  localparam logic [6:0] GroundY = 7'd116;

  // Sprite colours
  localparam logic [2:0] BirdCol = 3'b110;
  localparam logic [2:0] BgCol   = 3'b000;

  typedef enum logic [1:0] {SeqIdle, SeqErase, SeqPaint} seq_e;

endpackage

// File: rtl/sprite_scanner.sv
// Sprite scanner: erases the sprite at the old row, then paints it at the
// new row, one pixel per cycle, row-major with the column index fastest.
module sprite_scanner
  import bird_pkg::*;
#(
  parameter logic [7:0]  BIRD_X = 8'd40,
  parameter int unsigned BIRD_W = 4,
  parameter int unsigned BIRD_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] erase_row,
  input  logic [6:0] new_row,
  output logic [7:0] x,
  output logic [6:0] y_pix,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [6:0] paint_row
);

  seq_e       seq_q;
  logic [3:0] i_q, j_q;
  logic [6:0] paint_row_q;
  logic       last_col, last_row;

  assign last_col  = (i_q == 4'(BIRD_W - 1));
  assign last_row  = (j_q == 4'(BIRD_H - 1));
  assign done      = (seq_q == SeqPaint) && last_col && last_row;
  assign paint_row = paint_row_q;

  // Scan sequencing; the paint row is captured as ERASE finishes so a START
  // arriving before PAINT still lands in this redraw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q       <= SeqIdle;
      i_q         <= 4'd0;
      j_q         <= 4'd0;
      paint_row_q <= 7'd0;
    end else begin
      case (seq_q)
        SeqIdle: begin
          if (start) begin
            seq_q <= SeqErase;
            i_q   <= 4'd0;
            j_q   <= 4'd0;
          end
        end
        SeqErase, SeqPaint: begin
          if (last_col) begin
            i_q <= 4'd0;
            if (last_row) begin
              j_q <= 4'd0;
              if (seq_q == SeqErase) begin
                seq_q       <= SeqPaint;
                paint_row_q <= new_row;
              end else begin
                seq_q <= SeqIdle;
              end
            end else begin
              j_q <= j_q + 4'd1;
            end
          end else begin
            i_q <= i_q + 4'd1;
          end
        end
        default: seq_q <= SeqIdle;
      endcase
    end
  end

  // Pixel outputs; all zero while idle
  always_comb begin
    plot   = 1'b0;
    x      = 8'd0;
    y_pix  = 7'd0;
    colour = 3'b000;
    case (seq_q)
      SeqErase: begin
        plot   = 1'b1;
        x      = BIRD_X + {4'd0, i_q};
        y_pix  = erase_row + {3'd0, j_q};
        colour = BgCol;
      end
      SeqPaint: begin
        plot   = 1'b1;
        x      = BIRD_X + {4'd0, i_q};
        y_pix  = paint_row_q + {3'd0, j_q};
        colour = BirdCol;
      end
      default: ;
    endcase
  end

  assign busy = plot;

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: frame divider, bird Y motion, status flags for the bird FSM
// and the sprite redraw stream to the VGA adapter.
// Optional feature macro: BIRD_GRAVITY_EN (accelerating fall velocity).
module bird_datapath
  import bird_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter logic [7:0]  BIRD_X       = 8'd40,
  parameter int unsigned BIRD_W       = 4,
  parameter int unsigned BIRD_H       = 4,
  parameter logic [6:0]  START_Y      = 7'd56,
  parameter int unsigned RISE_STEP    = 2,
  parameter int unsigned FALL_STEP    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       pipe_hit,
  output logic       flag,
  output logic       touched,
  output logic [7:0] x,
  output logic [6:0] y_pix,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [6:0]  FloorY = GroundY - 7'(BIRD_H);
  localparam logic signed [7:0] FloorExt = {1'b0, FloorY};
  localparam logic signed [7:0] RiseStep = 8'(RISE_STEP);

  logic [CntW-1:0] cnt_q;
  logic            tick, idle, move, pending_q, drawn_q, start, done;
  logic [6:0]      y_q, y_d, old_y_q, paint_row;
  logic signed [7:0] y_ext, y_step, fall_amt;

  assign tick  = (cnt_q == CntW'(FRAME_CYCLES - 1));
  assign idle  = ~busy;
  assign move  = idle && (tick || pending_q);
  assign start = idle && ((y_q != old_y_q) || (state == StDraw && !drawn_q));

`ifdef BIRD_GRAVITY_EN
  logic [2:0] v_q;
  assign fall_amt = {5'd0, v_q};

  // Fall velocity: grows by one per applied fall, cleared by START/RAISING
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 3'd0;
    end else if (state == StStart || state == StRaising) begin
      v_q <= 3'd0;
    end else if (move && state == StFalling) begin
      v_q <= (v_q == 3'd7) ? 3'd7 : v_q + 3'd1;
    end
  end
`else
  assign fall_amt = 8'(FALL_STEP);
`endif

  // Free-running frame divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next Y; signed intermediate so rising past row 0 clamps instead of wrapping
  always_comb begin
    y_ext  = {1'b0, y_q};
    y_step = y_ext;
    y_d    = y_q;
    case (state)
      StStart: y_d = START_Y;
      StRaising: begin
        if (move) begin
          y_step = y_ext - RiseStep;
          y_d    = (y_step < 8'sd0) ? 7'd0 : y_step[6:0];
        end
      end
      StFalling: begin
        if (move) begin
          y_step = y_ext + fall_amt;
          y_d    = (y_step > FloorExt) ? FloorY : y_step[6:0];
        end
      end
      StStop, StDraw, StUpdate, StDel: y_d = y_q;
      default: y_d = y_q;
    endcase
  end

  // Position, deferred-move and redraw bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= START_Y;
      old_y_q   <= START_Y;
      pending_q <= 1'b0;
      drawn_q   <= 1'b0;
    end else begin
      y_q <= y_d;
      // An idle cycle always consumes the pending move; extra ticks are dropped
      if (idle) begin
        pending_q <= 1'b0;
      end else if (tick) begin
        pending_q <= 1'b1;
      end
      if (idle && state == StDraw) begin
        drawn_q <= 1'b1;
      end
      // Track the row actually painted, so a late START still triggers a redraw
      if (done) begin
        old_y_q <= paint_row;
      end
    end
  end

  // Registered status back to the bird FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag    <= 1'b0;
      touched <= 1'b0;
    end else begin
      flag    <= (y_q <= TopY);
      touched <= (y_q >= FloorY) || pipe_hit;
    end
  end

  sprite_scanner #(
    .BIRD_X (BIRD_X),
    .BIRD_W (BIRD_W),
    .BIRD_H (BIRD_H)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .erase_row (old_y_q),
    .new_row   (y_q),
    .x         (x),
    .y_pix     (y_pix),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done),
    .paint_row (paint_row)
  );

endmodule
